// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response, decoder-side queue head and redirect signals.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer issuing in-order imem requests into an instruction queue,
// with redirect flush and discard of responses still in flight from before the redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int          QUEUE_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW:0] DEPTH = (CW + 1)'(QUEUE_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   q_instr [QUEUE_DEPTH];
    logic [31:0]   q_pc    [QUEUE_DEPTH];
    logic [31:0]   tags    [QUEUE_DEPTH];
    logic [AW-1:0] q_head, q_tail, t_head, t_tail;
    logic [CW-1:0] q_count, outstanding, discard;
    logic          flush, req_fire, keep, pop;

    // Queue slots are reserved for every outstanding request, so a response always fits.
    always_comb begin
        flush              = bus.redirect_valid;
        bus.imem_req_valid = !rst && !flush && ({1'b0, q_count} + {1'b0, outstanding} < DEPTH);
        bus.imem_req_addr  = pc;
        req_fire           = bus.imem_req_valid && bus.imem_req_ready;
        keep               = bus.imem_resp_valid && discard == '0 && !flush;
        bus.out_valid      = q_count != '0;
        pop                = bus.out_valid && bus.out_ready && !flush;
        bus.out_instr      = bus.out_valid ? q_instr[q_head] : '0;
        bus.out_pc         = bus.out_valid ? q_pc[q_head] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            q_head      <= '0;
            q_tail      <= '0;
            t_head      <= '0;
            t_tail      <= '0;
            q_count     <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (flush) begin
            pc          <= bus.redirect_pc & ~32'd3;
            q_head      <= '0;
            q_tail      <= '0;
            t_head      <= '0;
            t_tail      <= '0;
            q_count     <= '0;
            outstanding <= outstanding - CW'(bus.imem_resp_valid);
            discard     <= outstanding - CW'(bus.imem_resp_valid);
        end else begin
            if (req_fire) begin
                pc     <= pc + 32'd4;
                t_tail <= t_tail + AW'(1);
            end
            if (keep) begin
                t_head <= t_head + AW'(1);
                q_tail <= q_tail + AW'(1);
            end
            if (pop)
                q_head <= q_head + AW'(1);
            q_count     <= q_count + CW'(keep) - CW'(pop);
            outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_resp_valid);
            if (bus.imem_resp_valid && discard != '0)
                discard <= discard - CW'(1);
        end
    end

    // Stale responses hold no tag: the tag FIFO is emptied on redirect and only kept responses pop it.
    always_ff @(posedge clk) begin
        if (req_fire)
            tags[t_tail] <= pc;
        if (keep) begin
            q_instr[q_tail] <= bus.imem_resp_data;
            q_pc[q_tail]    <= tags[t_head];
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: fetch_unit against an in-order memory model and an epoch-based expected-stream model.
module tb_fetch_unit;
    localparam int          QD = 4;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;

    fetch_unit_if f();
    fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(QD)) dut (.clk(clk), .rst(rst), .bus(f.master));

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] a0;
        logic [31:0] a1;
    } rvec_t;

    mreq_t       mq[$];
    rvec_t       tv[4];
    int          cyc, ep, qcnt, nfire, npop, tests, failed;
    int          lat_min = 1, lat_max = 1;
    logic [31:0] exp_pc, exp_req;

    function automatic logic [31:0] mem(logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0001_2345;
    endfunction

    task automatic check(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            failed++;
            $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        f.imem_req_ready = 0;
        f.imem_resp_valid = 0;
        f.imem_resp_data = 0;
        f.out_ready = 0;
        f.redirect_valid = 0;
        f.redirect_pc = 0;
        #1;
        check("rst_req_valid", f.imem_req_valid, 0);
        check("rst_out_valid", f.out_valid, 0);
        check("rst_out_pc", f.out_pc, 0);
        check("rst_out_instr", f.out_instr, 0);
        check("rst_req_addr", f.imem_req_addr, RPC);
        mq.delete();
        qcnt = 0;
        ep = 0;
        exp_pc = RPC;
        exp_req = RPC;
        @(negedge clk);
        rst = 0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(bit rdy, bit ordy, bit rv, logic [31:0] rpc);
        bit resp, stale, rf, of;
        resp = mq.size() > 0 && mq[0].due <= cyc;
        f.imem_req_ready = rdy;
        f.out_ready = ordy;
        f.redirect_valid = rv;
        f.redirect_pc = rpc;
        f.imem_resp_valid = resp;
        f.imem_resp_data = resp ? mem(mq[0].addr) : 32'hDEAD_BEEF;
        #1;
        check("req_valid", f.imem_req_valid, !rv && (qcnt + mq.size() < QD));
        check("out_valid", f.out_valid, qcnt != 0);
        if (f.out_valid) begin
            check("out_pc", f.out_pc, exp_pc);
            check("out_instr", f.out_instr, mem(exp_pc));
        end
        rf = f.imem_req_valid && rdy;
        of = f.out_valid && ordy;
        if (rf)
            check("req_addr", f.imem_req_addr, exp_req);
        if (resp) begin
            stale = mq[0].ep != ep;
            void'(mq.pop_front());
        end
        if (rv) begin
            ep++;
            qcnt = 0;
            exp_pc = rpc & ~32'd3;
            exp_req = rpc & ~32'd3;
        end else begin
            if (of) begin
                qcnt--;
                npop++;
                exp_pc += 4;
            end
            if (resp && !stale)
                qcnt++;
            if (rf) begin
                mq.push_back('{f.imem_req_addr, ep, cyc + int'($urandom_range(lat_max, lat_min))});
                nfire++;
                exp_req += 4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int n;
        tv[0] = '{32'h0000_3101, 32'h0000_3100, 32'h0000_3104};
        tv[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        tv[2] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
        tv[3] = '{32'h8000_0006, 32'h8000_0004, 32'h8000_0008};
        @(negedge clk);

        // Streaming at latency 1: one pop per cycle once the pipe fills.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        npop = 0;
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        check("stream_pops", npop, 10);

        // Decoder stalled: exactly QD requests, head held, then drain and resume.
        do_reset();
        nfire = 0;
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        check("stall_fires", nfire, QD);
        check("stall_head_pc", f.out_pc, RPC);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0);

        // Redirect with two requests in flight at latency 3.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("pre_redirect_outstanding", mq.size(), 2);
        step(1, 1, 1, 32'h0000_3101);
        check("redir_addr", f.imem_req_addr, 32'h0000_3100);
        check("redir_out_valid", f.out_valid, 0);
        for (int i = 0; i < 20 && !f.out_valid; i++) step(1, 1, 0, 0);
        check("first_pc_after_redirect", f.out_pc, 32'h0000_3100);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);

        // Redirect coinciding with a response and a pop, then back-to-back redirects.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 32'h0000_4000);
        check("coincide_out_valid", f.out_valid, 0);
        check("coincide_addr", f.imem_req_addr, 32'h0000_4000);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 32'h0000_5000);
        step(1, 1, 1, 32'h0000_6008);
        check("b2b_addr", f.imem_req_addr, 32'h0000_6008);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);

        // Redirect target table, including alignment and the 32-bit wrap.
        do_reset();
        lat_max = 3;
        foreach (tv[k]) begin
            for (int i = 0; i < 5; i++) step(1'($urandom), 1'($urandom), 0, 0);
            step(1, 1, 1, tv[k].rpc);
            check("tbl_addr", f.imem_req_addr, tv[k].a0);
            check("tbl_out_valid", f.out_valid, 0);
            n = nfire;
            for (int i = 0; i < 20 && nfire == n; i++) step(1, 1, 0, 0);
            check("tbl_next_addr", f.imem_req_addr, tv[k].a1);
            for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        end

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step(1'($urandom), 1'($urandom), $urandom_range(39, 0) == 0, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter QUEUE_DEPTH, default 4, instruction-queue entries (power of two, >=2).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address (current PC).
REQ-008 imem_resp_valid  input  1  instruction word returned (in request order, >=1 cycle after accept, no backpressure).
REQ-009 imem_resp_data  input  32  returned instruction word.
REQ-010 out_valid  output  1  queue head valid toward decoder.
REQ-011 out_ready  input  1  decoder consumes head this cycle.
REQ-012 out_instr  output  32  head instruction word (fed to decoder instr input).
REQ-013 out_pc  output  32  head instruction address.
REQ-014 redirect_valid  input  1  control-flow redirect (branch/jump resolved, flush).
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).

Function
REQ-016 Request accepted ("req_fire") iff imem_req_valid && imem_req_ready; PC then advances by 4, wrapping modulo 2^32.
REQ-017 imem_req_valid SHALL be 1 iff (queue_count + outstanding) < QUEUE_DEPTH and redirect_valid == 0; a response therefore always has a free queue slot.
REQ-018 outstanding counter: +1 on req_fire, -1 on imem_resp_valid, both same cycle -> unchanged; width holds 0..QUEUE_DEPTH.
REQ-019 Each accepted request records its PC in an in-order tag FIFO (depth QUEUE_DEPTH); the response pairs with the oldest tag.
REQ-020 Non-discarded response writes {data, tag PC} to queue tail the same edge; visible on out_* the next cycle (min fetch-to-out latency = memory latency + 1).
REQ-021 Head pop ("out_fire") iff out_valid && out_ready; push and pop in the same cycle both take effect, count unchanged; push when full never occurs (REQ-017); pop when empty ignored.
REQ-022 out_valid == (queue_count != 0); out_instr/out_pc driven from head register, held stable while out_valid && !out_ready.
REQ-023 Redirect (priority over all other events that cycle): queue and tag FIFO flushed (count 0, pointers 0), PC <= {redirect_pc[31:2],2'b00}, out_fire same cycle has no further effect, no request issued this cycle.
REQ-024 On redirect, discard_count <= outstanding minus (1 if imem_resp_valid that cycle); subsequent responses with discard_count != 0 are dropped and decrement discard_count, do not write the queue.
REQ-025 While discard_count != 0 new requests MAY issue (subject to REQ-017 counting outstanding); their responses are kept only after discard_count reaches 0.
REQ-026 Back-to-back redirects: each recomputes discard_count from current outstanding per REQ-024; last one wins PC.
REQ-027 Queue pointers wrap modulo QUEUE_DEPTH; count ranges 0..QUEUE_DEPTH.

Reset
REQ-028 rst asserted: immediately PC = RESET_PC, queue_count = 0, outstanding = 0, discard_count = 0, pointers = 0, out_valid = 0, imem_req_valid = 0; out_instr/out_pc = 0.
REQ-029 Reset mid-operation drops all in-flight responses' association; bench guarantees memory is reset concurrently; first request after deassertion (imem_req_valid = 1) in the first cycle after rst falls, addr = RESET_PC.

Verification
REQ-030 Reset release, memory ready=1, latency 1, out_ready=1 -> out_pc sequence 0x3000, 0x3004, 0x3008 ... one per cycle, instructions match memory image.
REQ-031 out_ready=0 held -> exactly QUEUE_DEPTH (4) requests issued, then imem_req_valid = 0; out_* stable; release -> 4 pops then streaming resumes at 0x3010.
REQ-032 Redirect to 0x0000_3101 with 2 requests outstanding -> next request addr 0x0000_3100, the 2 stale responses dropped, first out_pc after redirect = 0x3100, out_valid=0 in redirect cycle+1.
REQ-033 Redirect same cycle as a response and an out_fire -> response counted, discard_count = outstanding-1, queue empty next cycle, no duplicated or lost PC afterward.
REQ-034 imem_req_ready toggling randomly, latency 1-3 cycles, out_ready random -> out_pc strictly +4 between redirects, no gaps or duplicates, never overflow.
REQ-035 PC at 0xFFFF_FFFC -> next request addr 0x0000_0000 (wrap).
